// File: rtl/result_display_pkg.sv
// Shared constants, state encoding and seven-segment helper for the
// matrix result display stage.
package result_display_pkg;

  localparam int MATRIX_ELEMS = 25;
  localparam int ELEM_W       = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] SHOW    = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low segments in {g,f,e,d,c,b,a} order; non-decimal codes blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/result_display_button_debouncer.sv
// Synchronises and debounces the active-low step button, producing a
// single-cycle pulse for each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_0;
  logic          sync_1;
  logic          stable;
  logic [CW-1:0] cnt;

  // Released level is the idle state so power-up never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_0 <= 1'b1;
      sync_1 <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_0 <= btn_n;
      sync_1 <= sync_0;
      press  <= 1'b0;
      if (sync_1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_1;
        cnt    <= '0;
        press  <= stable & ~sync_1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_display.sv
// Captures a 25-element signed matrix and shows one element at a time in
// signed decimal on four seven-segment digits, stepped by a push-button.
module result_display
  import result_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [MATRIX_ELEMS*ELEM_W-1:0] matrix_in,
  input  logic                           step_n,
  output logic [4:0]                     index,
  output logic [6:0]                     hex0,
  output logic [6:0]                     hex1,
  output logic [6:0]                     hex2,
  output logic [6:0]                     hex3,
  output logic                           busy,
  output logic                           valid
);

  logic [1:0]                     state;
  logic [MATRIX_ELEMS*ELEM_W-1:0] matrix;
  logic [3:0]                     iter;
  logic [7:0]                     shift;
  logic [11:0]                    bcd;
  logic                           neg;
  logic                           press;
  logic                           step_ok;
  logic                           start;
  logic [4:0]                     next_index;
  logic [ELEM_W-1:0]              sel_elem;
  logic [11:0]                    bcd_adj;
  logic [11:0]                    bcd_next;
  logic [7:0]                     shift_next;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst   (rst),
    .btn_n (step_n),
    .press (press)
  );

  // Load has priority; a press only counts once the current element is shown.
  assign step_ok    = press && !load && (state == SHOW);
  assign start      = load || step_ok;
  assign next_index = (load || index == 5'(MATRIX_ELEMS - 1)) ? 5'd0 : index + 5'd1;
  assign busy       = (state == CONVERT);

  always_comb begin
    sel_elem = matrix_in[ELEM_W-1:0];
    if (!load) begin
      sel_elem = '0;
      for (int k = 0; k < MATRIX_ELEMS; k++) begin
        if (5'(k) == next_index) sel_elem = matrix[k*ELEM_W +: ELEM_W];
      end
    end
  end

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < 3; d++) begin
      if (bcd_adj[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_adj[d*4 +: 4] + 4'd3;
    end
    {bcd_next, shift_next} = {bcd_adj, shift} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      matrix <= '0;
      index  <= '0;
      iter   <= '0;
      shift  <= '0;
      bcd    <= '0;
      neg    <= 1'b0;
      hex0   <= SEG_BLANK;
      hex1   <= SEG_BLANK;
      hex2   <= SEG_BLANK;
      hex3   <= SEG_BLANK;
      valid  <= 1'b0;
    end else if (start) begin
      if (load) matrix <= matrix_in;
      index <= next_index;
      neg   <= sel_elem[7];
      shift <= sel_elem[7] ? (~sel_elem + 8'd1) : sel_elem;
      bcd   <= '0;
      iter  <= '0;
      valid <= 1'b0;
      state <= CONVERT;
    end else if (state == CONVERT) begin
      if (iter == 4'd8) begin
        hex0  <= digit_to_seg(bcd[3:0]);
        hex1  <= (bcd[11:4] == 8'd0) ? SEG_BLANK : digit_to_seg(bcd[7:4]);
        hex2  <= (bcd[11:8] == 4'd0) ? SEG_BLANK : digit_to_seg(bcd[11:8]);
        hex3  <= neg ? SEG_MINUS : SEG_BLANK;
        valid <= 1'b1;
        state <= SHOW;
      end else begin
        bcd   <= bcd_next;
        shift <= shift_next;
        iter  <= iter + 4'd1;
      end
    end
  end

endmodule

// File: doc/result_display.md
# result_display

Downstream display stage for the matrix coprocessor. Captures the 200-bit packed result (25 signed 8-bit elements, element 0 in bits [7:0]) when the coprocessor finishes. Lets the operator step through the elements with a debounced push-button. Each element is shown in signed decimal on four active-low seven-segment digits, with the element index on LEDs.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, number of clk cycles `step_n` must stay stable before a level change is accepted (20 ms at 50 MHz).
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  one-cycle strobe; captures `matrix_in`.
- matrix_in  in  200  packed result; element k at bits [8k+7:8k], two's complement.
- step_n  in  1  raw push-button, active-low (pressed = 0), asynchronous to clk.
- index  out  5  element currently shown, 0..24.
- hex0  out  7  units digit, active-low, segment order {g,f,e,d,c,b,a}.
- hex1  out  7  tens digit.
- hex2  out  7  hundreds digit.
- hex3  out  7  sign digit.
- busy  out  1  conversion in progress.
- valid  out  1  displays reflect `index` of the captured matrix.

## Operation
- States:
  - IDLE: waiting, nothing captured yet.
  - CONVERT: binary-to-BCD conversion in progress.
  - SHOW: displays valid.
- Reset values: state IDLE; captured matrix 0; index 0; hex0..hex3 = 7'b1111111 (blank); busy 0; valid 0.
- load, any state: capture `matrix_in`, set index 0, clear valid, enter CONVERT. An in-flight conversion is abandoned and restarted.
- Step press, SHOW only: index increments, 24 wraps to 0; clear valid; enter CONVERT.
  - Step press in IDLE or CONVERT: dropped, not queued.
- load and step press in the same cycle: load wins, index 0, step dropped.
- CONVERT sequence:
  - Take the selected element e.
  - neg = e[7]; mag = neg ? -e : e, as 8-bit unsigned (-128 gives 128).
  - Double-dabble over 8 iterations, one per cycle, into 12-bit BCD {H,T,U}.
  - On the last iteration, register the hex outputs, set valid, enter SHOW.
- Digit encoding, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Leading-zero blanking:
  - hex2 is blank when H = 0.
  - hex1 is blank when H = 0 and T = 0.
  - hex0 always shows a digit.
- hex3: 7'b0111111 (minus, segment g only) when neg; blank otherwise.
- Debounce path:
  - `step_n` passes through a 2-flop synchronizer.
  - A counter runs while the synchronized level differs from the accepted level, and clears when they match.
  - At DEBOUNCE_CYCLES-1 the accepted level updates.
  - A press is a 1→0 transition of the accepted level, one pulse per press; holding the button gives exactly one step.

## Timing
- Accepted event (load or step) sampled at edge E:
  - busy rises after E.
  - BCD iterations run at edges E+1..E+8.
  - hex0..hex3, valid=1, busy=0 all update together at edge E+9.
- index updates at E, before the displays. Consumers qualify the displays with valid.
- Step latency from a physical press: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle, then 9 cycles of conversion.
- A glitch on `step_n` shorter than DEBOUNCE_CYCLES cycles produces no step.
- Reset during CONVERT: all outputs return to their reset values immediately (asynchronous); nothing resumes after reset.

## Structure
- Shared package `result_display_pkg` holds:
  - MATRIX_ELEMS = 25 and ELEM_W = 8;
  - the state encoding (IDLE, CONVERT, SHOW);
  - the SEG_BLANK and SEG_MINUS constants;
  - the digit-to-segment function.
- One sub-module, `button_debouncer`: synchronizer, counter, and press-pulse output, parameterised by DEBOUNCE_CYCLES.
- The top level contains the capture register, index counter, FSM, and double-dabble datapath.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 4.
- Reset then load with element 0 = 7 → nine cycles later:
  - hex0 = 1111000 (7);
  - hex1, hex2, hex3 blank;
  - index 0, valid 1.
- Element 1 = -128, single clean press → index 1:
  - hex3 = 0111111 (minus), hex2 = 1111001 (1), hex1 = 0100100 (2), hex0 = 0000000 (8).
- Element 2 = 100 → hex2 = 1111001 (1), hex1 = 1000000 (0), hex0 = 1000000 (0), hex3 blank.
- Element 3 = -5 → hex0 = 0010010 (5), hex3 = minus, hex1 and hex2 blank.
- Wrap and glitches:
  - 25 separated presses from index 0 → index returns to 0.
  - A 2-cycle low glitch on step_n → index unchanged.
  - Button held low for 100 cycles → exactly one increment.
- Conflicts and reset:
  - load and step press in the same cycle at index 5 → index 0.
  - Press during CONVERT → ignored.
  - rst asserted mid-CONVERT → hex all 1111111, valid 0, busy 0, index 0.
